// File: rtl/fft_band_energy_pkg.sv
// Shared types and constants for the band-energy engine.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int LVL_W = 4;

    // Accumulator must hold 2^ADDR_W squared samples without wrapping.
    function automatic int acc_w(input int data_w, input int addr_w);
        return 2 * data_w + addr_w;
    endfunction

endpackage

// File: rtl/fft_band_energy_if.sv
// BRAM read port: address out, data back RD_LAT cycles later.
interface fft_band_energy_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;

    modport master (output bram_addr, input bram_data);
    modport slave  (input bram_addr, output bram_data);
endinterface

// File: rtl/fft_band_energy_band_level_map.sv
// Maps one band energy to a display level: shift, saturate, peak-decay, hold.
module band_level_map #(
    parameter int ACC_W = 42,
    parameter int LVL_W = 4
) (
    input  logic [ACC_W-1:0] energy,
    input  logic [5:0]       shift,
    input  logic [LVL_W-1:0] cur_lvl,
    input  logic             hold,
    input  logic             peak_mode,
    output logic [LVL_W-1:0] nxt_lvl
);
    localparam logic [ACC_W-1:0] LVL_MAX = ACC_W'((1 << LVL_W) - 1);

    logic [ACC_W-1:0] shifted;
    logic [LVL_W-1:0] new_lvl;
    logic [LVL_W-1:0] decayed;

    // Saturating level, then choose between fresh, peak-decayed or held value.
    always_comb begin
        shifted = energy >> shift;
        new_lvl = (shifted > LVL_MAX) ? {LVL_W{1'b1}} : shifted[LVL_W-1:0];
        decayed = (cur_lvl == '0) ? '0 : cur_lvl - LVL_W'(1);
        if (hold)
            nxt_lvl = cur_lvl;
        else if (peak_mode)
            nxt_lvl = (new_lvl > decayed) ? new_lvl : decayed;
        else
            nxt_lvl = new_lvl;
    end
endmodule

// File: rtl/fft_band_energy.sv
// Per-band energy of an FFT magnitude frame read from BRAM, plus level mapping.
module fft_band_energy #(
    parameter int NUM_BINS = 7,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 2,
    parameter int LVL_W    = fft_pkg::LVL_W,
    localparam int ACC_W   = fft_pkg::acc_w(DATA_W, ADDR_W),
    localparam int IDX_W   = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_BINS*(ADDR_W+1)-1:0] bounds,
    input  logic [NUM_BINS*6-1:0]     shift,
    input  logic                      hold,
    input  logic                      peak_mode,
    fft_band_energy_if.master         bram,
    output logic                      busy,
    output logic                      done,
    output logic [ACC_W-1:0]          energy,
    output logic                      energy_valid,
    output logic [IDX_W-1:0]          energy_idx,
    output logic [NUM_BINS*LVL_W-1:0] level,
    output logic                      bounds_err
);
    import fft_pkg::*;

    localparam int BW = ADDR_W + 1;

    state_t                           state_q, state_d;
    logic [NUM_BINS-1:0][BW-1:0]      bnd_q;
    logic [NUM_BINS-1:0][5:0]         shf_q;
    logic [NUM_BINS-1:0][LVL_W-1:0]   lvl_q;
    logic [IDX_W-1:0]                 band_q, out_idx_q;
    logic [BW-1:0]                    addr_q, cur_bnd;
    logic [ADDR_W-1:0]                bram_addr_q;
    logic [RD_LAT:0]                  vld_pipe, tok_pipe;
    logic [ACC_W-1:0]                 acc_q;
    logic [LVL_W-1:0]                 lvl_nxt;
    logic accept, issue_rd, issue_tok, last_band, frame_end, bad_bounds;

    assign cur_bnd        = bnd_q[band_q];
    assign last_band      = (band_q == IDX_W'(NUM_BINS - 1));
    assign frame_end      = energy_valid && (energy_idx == IDX_W'(NUM_BINS - 1));
    assign busy           = (state_q != IDLE);
    assign level          = lvl_q;
    assign bram.bram_addr = bram_addr_q;

    // Flag any band whose end lies below the previous band's end.
    always_comb begin
        bad_bounds = 1'b0;
        for (int k = 1; k < NUM_BINS; k++)
            if (bounds[k*BW +: BW] < bounds[(k-1)*BW +: BW])
                bad_bounds = 1'b1;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and per-cycle issue decision; a start coinciding with done is refused.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        issue_rd  = 1'b0;
        issue_tok = 1'b0;
        case (state_q)
            IDLE: if (start && !done) begin
                accept  = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: if (addr_q < cur_bnd) begin
                issue_rd = 1'b1;
            end else begin
                issue_tok = 1'b1;
                if (last_band) state_d = DRAIN;
            end
            DRAIN: if (frame_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address generation, read-aligned pipe, accumulation and band retirement.
    always_ff @(posedge clock) begin
        if (reset) begin
            bnd_q        <= '0;
            shf_q        <= '0;
            lvl_q        <= '0;
            band_q       <= '0;
            out_idx_q    <= '0;
            addr_q       <= '0;
            bram_addr_q  <= '0;
            vld_pipe     <= '0;
            tok_pipe     <= '0;
            acc_q        <= '0;
            energy       <= '0;
            energy_valid <= 1'b0;
            energy_idx   <= '0;
            done         <= 1'b0;
            bounds_err   <= 1'b0;
        end else begin
            done         <= (state_q == DRAIN) && frame_end;
            energy_valid <= 1'b0;
            vld_pipe     <= {vld_pipe[RD_LAT-1:0], issue_rd};
            tok_pipe     <= {tok_pipe[RD_LAT-1:0], issue_tok};
            if (accept) begin
                bnd_q      <= bounds;
                shf_q      <= shift;
                bounds_err <= bad_bounds;
                band_q     <= '0;
                out_idx_q  <= '0;
                addr_q     <= '0;
                acc_q      <= '0;
            end
            if (issue_rd) begin
                bram_addr_q <= addr_q[ADDR_W-1:0];
                addr_q      <= addr_q + 1'b1;
            end
            // Next band starts at this band's end, even when the bound went backwards.
            if (issue_tok) begin
                addr_q <= cur_bnd;
                if (!last_band) band_q <= band_q + 1'b1;
            end
            if (vld_pipe[RD_LAT])
                acc_q <= acc_q + ACC_W'(bram.bram_data) * ACC_W'(bram.bram_data);
            if (tok_pipe[RD_LAT]) begin
                energy       <= acc_q;
                energy_valid <= 1'b1;
                energy_idx   <= out_idx_q;
                out_idx_q    <= out_idx_q + 1'b1;
                acc_q        <= '0;
            end
            if (energy_valid)
                lvl_q[energy_idx] <= lvl_nxt;
        end
    end

    band_level_map #(.ACC_W(ACC_W), .LVL_W(LVL_W)) u_level_map (
        .energy    (energy),
        .shift     (shf_q[energy_idx]),
        .cur_lvl   (lvl_q[energy_idx]),
        .hold      (hold),
        .peak_mode (peak_mode),
        .nxt_lvl   (lvl_nxt)
    );
endmodule

// File: tb/tb_fft_band_energy.sv
// Randomized and directed checks of fft_band_energy against a frame-level model.
module tb_fft_band_energy;
    localparam int NB = 7, AW = 10, DW = 16, RL = 2, LW = 4;
    localparam int SW = AW + 1, ACC = 2*DW + AW, IW = 3;

    logic clock = 1'b0, reset = 1'b1, start = 1'b0, hold = 1'b0, peak_mode = 1'b0;
    logic [NB*SW-1:0] bounds = '0;
    logic [NB*6-1:0]  shift = '0;
    logic busy, done, energy_valid, bounds_err;
    logic [ACC-1:0]   energy;
    logic [IW-1:0]    energy_idx;
    logic [NB*LW-1:0] level;

    fft_band_energy_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    fft_band_energy #(.NUM_BINS(NB), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .LVL_W(LW)) dut (
        .clock(clock), .reset(reset), .start(start), .bounds(bounds), .shift(shift),
        .hold(hold), .peak_mode(peak_mode), .bram(bus), .busy(busy), .done(done),
        .energy(energy), .energy_valid(energy_valid), .energy_idx(energy_idx),
        .level(level), .bounds_err(bounds_err));

    always #5 clock = ~clock;

    // BRAM model with RL cycles of read latency.
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] rdp [RL];
    always @(posedge clock) begin
        rdp[0] <= mem[bus.bram_addr];
        for (int i = 1; i < RL; i++) rdp[i] <= rdp[i-1];
    end
    assign bus.bram_data = rdp[RL-1];

    logic [SW-1:0]     tb_bnd [NB];
    logic [5:0]        tb_shf [NB];
    longint unsigned   exp_e [NB], got_e [NB];
    logic [LW-1:0]     exp_lvl [NB], snap_lvl [NB];
    int                got_i [NB];
    bit                exp_err;
    int n_strobe, n_done, last_ev, done_at;
    int vectors = 0, miscompares = 0;

    // Reference: band k sums squares over [end(k-1), end(k)); levels follow the mapping rules.
    function automatic void model_frame();
        longint unsigned e, nl;
        logic [LW-1:0] dec;
        int lo;
        lo = 0;
        exp_err = 1'b0;
        for (int k = 0; k < NB; k++) begin
            e = 0;
            if (int'(tb_bnd[k]) < lo) exp_err = 1'b1;
            for (int a = lo; a < int'(tb_bnd[k]); a++) e += longint'(mem[a]) * longint'(mem[a]);
            exp_e[k] = e;
            lo = int'(tb_bnd[k]);
            nl = e >> tb_shf[k];
            if (nl > longint'((1 << LW) - 1)) nl = (1 << LW) - 1;
            dec = (exp_lvl[k] == 0) ? 4'd0 : exp_lvl[k] - 4'd1;
            if (!hold) exp_lvl[k] = peak_mode ? ((4'(nl) > dec) ? 4'(nl) : dec) : 4'(nl);
        end
    endfunction

    task automatic start_frame();
        for (int k = 0; k < NB; k++) begin
            bounds[k*SW +: SW] = tb_bnd[k];
            shift[k*6 +: 6]    = tb_shf[k];
        end
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    // Observe one frame already started; bounded by a cycle budget.
    task automatic collect_frame();
        n_strobe = 0; n_done = 0; last_ev = -10; done_at = -1;
        for (int k = 0; k < NB; k++) begin got_e[k] = '1; got_i[k] = -1; end
        for (int c = 0; c < 4000; c++) begin
            if (energy_valid === 1'b1) begin
                if (n_strobe < NB) begin got_e[n_strobe] = 64'(energy); got_i[n_strobe] = int'(energy_idx); end
                n_strobe++; last_ev = c;
            end
            if (done === 1'b1) begin n_done++; if (done_at < 0) done_at = c; end
            if (done_at >= 0 && c >= done_at + 3) break;
            @(negedge clock);
        end
    endtask

    task automatic set_ramp();
        for (int a = 0; a < 1024; a++) mem[a] = DW'(a);
        for (int k = 0; k < NB; k++) begin tb_bnd[k] = SW'(4*(k+1)); tb_shf[k] = 6'd0; end
    endtask

    task automatic test_reset();
        for (int k = 0; k < NB; k++) exp_lvl[k] = '0;
        for (int i = 0; i < RL; i++) rdp[i] = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (energy_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ev: got %b expected 0", energy_valid); end
        vectors++; if (bounds_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", bounds_err); end
        vectors++; if (energy !== '0) begin miscompares++; $display("FAIL reset_energy: got %0d expected 0", energy); end
        vectors++; if (bus.bram_addr !== '0) begin miscompares++; $display("FAIL reset_addr: got %0d expected 0", bus.bram_addr); end
        vectors++; if (level !== '0) begin miscompares++; $display("FAIL reset_level: got %h expected 0", level); end
    endtask

    task automatic test_ramp();
        set_ramp(); hold = 1'b0; peak_mode = 1'b0;
        model_frame(); start_frame(); collect_frame();
        vectors++; if (done_at < 0) begin miscompares++; $display("FAIL ramp_timeout: got no done expected done"); end
        vectors++; if (n_strobe !== NB) begin miscompares++; $display("FAIL ramp_strobes: got %0d expected %0d", n_strobe, NB); end
        vectors++; if (n_done !== 1) begin miscompares++; $display("FAIL ramp_done_count: got %0d expected 1", n_done); end
        vectors++; if (done_at !== last_ev + 1) begin miscompares++; $display("FAIL ramp_done_timing: got %0d expected %0d", done_at, last_ev + 1); end
        vectors++; if (got_e[0] !== 64'd14) begin miscompares++; $display("FAIL ramp_band0: got %0d expected 14", got_e[0]); end
        vectors++; if (got_e[1] !== 64'd126) begin miscompares++; $display("FAIL ramp_band1: got %0d expected 126", got_e[1]); end
        for (int k = 0; k < NB; k++) begin
            vectors++; if (got_e[k] !== exp_e[k] || got_i[k] !== k) begin miscompares++; $display("FAIL ramp_energy[%0d]: got %0d idx %0d expected %0d idx %0d", k, got_e[k], got_i[k], exp_e[k], k); end
            vectors++; if (level[k*LW +: LW] !== exp_lvl[k]) begin miscompares++; $display("FAIL ramp_level[%0d]: got %0d expected %0d", k, level[k*LW +: LW], exp_lvl[k]); end
        end
        vectors++; if (bus.bram_addr !== 10'd27) begin miscompares++; $display("FAIL ramp_addr_hold: got %0d expected 27", bus.bram_addr); end
    endtask

    task automatic test_full_scale();
        for (int a = 0; a < 1024; a++) mem[a] = 16'hFFFF;
        for (int k = 0; k < NB; k++) begin tb_bnd[k] = SW'(1024); tb_shf[k] = (k == 0) ? 6'd38 : 6'd0; end
        model_frame(); start_frame(); collect_frame();
        vectors++; if (n_strobe !== NB) begin miscompares++; $display("FAIL full_strobes: got %0d expected %0d", n_strobe, NB); end
        vectors++; if (got_e[0] !== 64'd1024 * 64'hFFFE0001) begin miscompares++; $display("FAIL full_band0: got %0d expected %0d", got_e[0], 64'd1024 * 64'hFFFE0001); end
        for (int k = 1; k < NB; k++) begin
            vectors++; if (got_e[k] !== 64'd0) begin miscompares++; $display("FAIL full_empty[%0d]: got %0d expected 0", k, got_e[k]); end
        end
        vectors++; if (level[LW-1:0] !== 4'd15) begin miscompares++; $display("FAIL full_level0: got %0d expected 15", level[LW-1:0]); end
        vectors++; if (bounds_err !== 1'b0) begin miscompares++; $display("FAIL full_err: got %b expected 0", bounds_err); end
    endtask

    task automatic test_peak();
        logic [LW-1:0] want [2];
        want[0] = 4'd14; want[1] = 4'd13;
        for (int a = 0; a < 1024; a++) mem[a] = '0;
        for (int k = 0; k < NB; k++) begin tb_bnd[k] = SW'(4*(k+1)); tb_shf[k] = 6'd38; end
        peak_mode = 1'b1;
        for (int f = 0; f < 2; f++) begin
            model_frame(); start_frame(); collect_frame();
            vectors++; if (level[LW-1:0] !== want[f]) begin miscompares++; $display("FAIL peak_decay[%0d]: got %0d expected %0d", f, level[LW-1:0], want[f]); end
            for (int k = 0; k < NB; k++) begin
                vectors++; if (level[k*LW +: LW] !== exp_lvl[k]) begin miscompares++; $display("FAIL peak_level[%0d]: got %0d expected %0d", k, level[k*LW +: LW], exp_lvl[k]); end
            end
        end
        peak_mode = 1'b0;
    endtask

    task automatic test_empty_bands();
        set_ramp();
        tb_bnd[2] = SW'(8); tb_bnd[3] = SW'(5); tb_bnd[4] = SW'(12); tb_bnd[5] = SW'(16); tb_bnd[6] = SW'(20);
        model_frame(); start_frame(); collect_frame();
        vectors++; if (got_e[2] !== 64'd0) begin miscompares++; $display("FAIL empty_equal: got %0d expected 0", got_e[2]); end
        vectors++; if (got_e[3] !== 64'd0) begin miscompares++; $display("FAIL empty_reverse: got %0d expected 0", got_e[3]); end
        for (int k = 0; k < NB; k++) begin
            vectors++; if (got_e[k] !== exp_e[k]) begin miscompares++; $display("FAIL empty_energy[%0d]: got %0d expected %0d", k, got_e[k], exp_e[k]); end
        end
        vectors++; if (bounds_err !== exp_err) begin miscompares++; $display("FAIL empty_err_set: got %b expected %b", bounds_err, exp_err); end
        set_ramp(); model_frame(); start_frame();
        vectors++; if (bounds_err !== 1'b0) begin miscompares++; $display("FAIL empty_err_clear: got %b expected 0", bounds_err); end
        collect_frame();
        vectors++; if (n_strobe !== NB) begin miscompares++; $display("FAIL empty_next_strobes: got %0d expected %0d", n_strobe, NB); end
    endtask

    task automatic test_hold();
        int lo;
        lo = 0;
        for (int a = 0; a < 128; a++) mem[a] = DW'($urandom);
        for (int k = 0; k < NB; k++) begin
            lo += $urandom_range(0, 12); tb_bnd[k] = SW'(lo); tb_shf[k] = 6'($urandom_range(0, 20));
            snap_lvl[k] = level[k*LW +: LW];
        end
        hold = 1'b1;
        model_frame(); start_frame(); collect_frame();
        vectors++; if (n_strobe !== NB) begin miscompares++; $display("FAIL hold_strobes: got %0d expected %0d", n_strobe, NB); end
        for (int k = 0; k < NB; k++) begin
            vectors++; if (got_e[k] !== exp_e[k]) begin miscompares++; $display("FAIL hold_energy[%0d]: got %0d expected %0d", k, got_e[k], exp_e[k]); end
            vectors++; if (level[k*LW +: LW] !== snap_lvl[k]) begin miscompares++; $display("FAIL hold_level[%0d]: got %0d expected %0d", k, level[k*LW +: LW], snap_lvl[k]); end
        end
        hold = 1'b0;
    endtask

    task automatic test_random();
        int lo;
        for (int f = 0; f < 6; f++) begin
            lo = 0;
            for (int a = 0; a < 128; a++) mem[a] = DW'($urandom);
            for (int k = 0; k < NB; k++) begin
                lo += $urandom_range(0, 12); tb_bnd[k] = SW'(lo); tb_shf[k] = 6'($urandom_range(24, 36));
            end
            peak_mode = 1'($urandom_range(0, 1));
            model_frame(); start_frame(); collect_frame();
            vectors++; if (n_strobe !== NB || n_done !== 1) begin miscompares++; $display("FAIL rand_counts[%0d]: got %0d strobes %0d done expected %0d strobes 1 done", f, n_strobe, n_done, NB); end
            vectors++; if (done_at !== last_ev + 1) begin miscompares++; $display("FAIL rand_done_timing[%0d]: got %0d expected %0d", f, done_at, last_ev + 1); end
            for (int k = 0; k < NB; k++) begin
                vectors++; if (got_e[k] !== exp_e[k] || got_i[k] !== k) begin miscompares++; $display("FAIL rand_energy[%0d][%0d]: got %0d idx %0d expected %0d", f, k, got_e[k], got_i[k], exp_e[k]); end
                vectors++; if (level[k*LW +: LW] !== exp_lvl[k]) begin miscompares++; $display("FAIL rand_level[%0d][%0d]: got %0d expected %0d", f, k, level[k*LW +: LW], exp_lvl[k]); end
            end
        end
        peak_mode = 1'b0;
    endtask

    // Start held high throughout: the done cycle must not launch a frame, the next cycle does.
    task automatic test_back_to_back();
        int c;
        set_ramp();
        model_frame(); model_frame();
        for (int k = 0; k < NB; k++) begin bounds[k*SW +: SW] = tb_bnd[k]; shift[k*6 +: 6] = tb_shf[k]; end
        @(negedge clock); start = 1'b1;
        @(negedge clock);
        for (c = 0; c < 500; c++) begin
            if (done === 1'b1) break;
            @(negedge clock);
        end
        vectors++; if (c >= 500) begin miscompares++; $display("FAIL b2b_timeout: got no done expected done"); end
        @(negedge clock);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_start_on_done: got busy %b expected 0", busy); end
        @(negedge clock);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_restart: got busy %b expected 1", busy); end
        start = 1'b0;
        collect_frame();
        vectors++; if (n_strobe !== NB || n_done !== 1) begin miscompares++; $display("FAIL b2b_counts: got %0d strobes %0d done expected %0d strobes 1 done", n_strobe, n_done, NB); end
        for (int k = 0; k < NB; k++) begin
            vectors++; if (got_e[k] !== exp_e[k]) begin miscompares++; $display("FAIL b2b_energy[%0d]: got %0d expected %0d", k, got_e[k], exp_e[k]); end
        end
    endtask

    task automatic test_reset_mid();
        int extra;
        set_ramp(); start_frame();
        repeat (4) @(negedge clock);
        start = 1'b1; @(negedge clock); start = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || energy_valid !== 1'b0 || bounds_err !== 1'b0) begin miscompares++; $display("FAIL midreset_flags: got busy %b done %b ev %b err %b expected all 0", busy, done, energy_valid, bounds_err); end
        vectors++; if (energy !== '0 || energy_idx !== '0) begin miscompares++; $display("FAIL midreset_energy: got %0d idx %0d expected 0 idx 0", energy, energy_idx); end
        vectors++; if (bus.bram_addr !== '0) begin miscompares++; $display("FAIL midreset_addr: got %0d expected 0", bus.bram_addr); end
        vectors++; if (level !== '0) begin miscompares++; $display("FAIL midreset_level: got %h expected 0", level); end
        reset = 1'b0;
        extra = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            if (busy !== 1'b0 || energy_valid !== 1'b0 || done !== 1'b0) extra++;
        end
        vectors++; if (extra !== 0) begin miscompares++; $display("FAIL midreset_no_frame: got %0d active cycles expected 0", extra); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_full_scale();
        test_peak();
        test_empty_bands();
        test_hold();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fft_band_energy.md
FFT_BAND_ENERGY -- requirements
Module: fft_band_energy

Interface
REQ-001 SHALL have parameter NUM_BINS, default 7, number of frequency bands.
REQ-002 SHALL have parameter ADDR_W, default 10, BRAM address width.
REQ-003 SHALL have parameter DATA_W, default 16, unsigned magnitude width.
REQ-004 SHALL have parameter RD_LAT, default 2, BRAM read latency in cycles (1..4).
REQ-005 SHALL have parameter LVL_W, default 4, per-band level width.
REQ-006 SHALL have derived constant ACC_W = 2*DATA_W+ADDR_W, the accumulator width.
REQ-007 SHALL have port clock, input, 1, rising-edge clock.
REQ-008 SHALL have port reset, input, 1, synchronous, active-high.
REQ-009 SHALL have port start, input, 1, frame request, sampled in IDLE only.
REQ-010 SHALL have port bounds, input, NUM_BINS*(ADDR_W+1), exclusive end address of band k in slice k; band k covers [bound(k-1), bound(k)), with bound(-1)=0.
REQ-011 SHALL have port shift, input, NUM_BINS*6, right-shift amount per band for level mapping.
REQ-012 SHALL have port hold, input, 1, freezes level updates.
REQ-013 SHALL have port peak_mode, input, 1, enables peak-hold with decay.
REQ-014 SHALL have port bram_addr, output, ADDR_W, read address.
REQ-015 SHALL have port bram_data, input, DATA_W, read data, valid RD_LAT cycles after bram_addr.
REQ-016 SHALL have port busy, output, 1, high from accepted start until done.
REQ-017 SHALL have port done, output, 1, one-cycle pulse at frame end.
REQ-018 SHALL have port energy, output, ACC_W, band energy.
REQ-019 SHALL have port energy_valid, output, 1, one-cycle strobe per band.
REQ-020 SHALL have port energy_idx, output, clog2(NUM_BINS), band index of energy.
REQ-021 SHALL have port level, output, NUM_BINS*LVL_W, registered per-band levels.
REQ-022 SHALL have port bounds_err, output, 1, sticky non-monotonic-bounds flag.

Function
REQ-023 SHALL latch bounds and shift when start is accepted in IDLE, and ignore later changes to them until done.
REQ-024 SHALL use FSM states IDLE → ISSUE → DRAIN → IDLE; accepted start moves IDLE→ISSUE, the last band token issued moves ISSUE→DRAIN, and the last token retired moves DRAIN→IDLE with done.
REQ-025 SHALL, in ISSUE, issue one address per cycle for band k from its start to bound(k)-1, followed by one end-of-band token cycle with no read.
REQ-026 SHALL carry valid and token flags down an RD_LAT-deep shift register aligned to bram_data.
REQ-027 SHALL, on each aligned valid sample, add bram_data*bram_data to the accumulator, with no wrap.
REQ-028 SHALL, on each aligned token, present the accumulator on energy with energy_valid=1 and energy_idx=k the following cycle, then clear the accumulator.
REQ-029 SHALL compute new_lvl = min((energy >> shift_k), 2^LVL_W-1).
REQ-030 SHALL, with hold=0 and peak_mode=0, set level_k to new_lvl.
REQ-031 SHALL, with hold=0 and peak_mode=1, set level_k to max(new_lvl, level_k-1 saturating at 0).
REQ-032 SHALL, with hold=1, leave level unchanged while energy and energy_valid still stream.
REQ-033 SHALL treat a band with bound(k)==bound(k-1) as empty: token only, energy 0.
REQ-034 SHALL treat a band with bound(k)<bound(k-1) as empty, set bounds_err, and clear bounds_err only on the next accepted start.
REQ-035 SHALL give frame length = bound(NUM_BINS-1) + NUM_BINS issue cycles; done SHALL pulse the cycle after the final energy_valid.
REQ-036 SHALL ignore start while busy; start and done in the same cycle SHALL NOT start a frame (the next start is accepted in IDLE).
REQ-037 SHALL hold bram_addr at its last value when no read is issued.

Reset
REQ-038 SHALL, on reset at any cycle including mid-frame, go to IDLE; busy, done, energy_valid, bounds_err = 0; energy, energy_idx, bram_addr, accumulator, pipe flags = 0; level = all zeros.

Structure
REQ-039 SHALL place FSM state enum, LVL_W and the ACC_W formula in shared package fft_pkg.
REQ-040 SHALL implement level mapping (shift, saturate, peak/decay, hold) as sub-module band_level_map, instantiated once, time-shared by energy_idx.

Verification
REQ-041 Bench SHALL cover: NUM_BINS=7, RD_LAT=2, bounds 4,8,...,28, bram_data=addr → energy_valid 7 times, band0 energy=14, band1 energy=126, done once.
REQ-042 Bench SHALL cover: bram_data=16'hFFFF over 1024 addresses in one band → energy = 1024*0xFFFE0001, no overflow.
REQ-043 Bench SHALL cover: bound(2)=bound(1)=8 → band2 energy 0; bound(3)=5 → band3 energy 0, bounds_err=1 until next start.
REQ-044 Bench SHALL cover: peak_mode=1, band0 level 15 then two frames of zero data → level 14, then 13.
REQ-045 Bench SHALL cover: hold=1 throughout a frame → level unchanged, energy strobes still produced.
REQ-046 Bench SHALL cover: reset asserted mid-ISSUE plus start pulses while busy → IDLE next cycle, all outputs 0, no extra frame.
